// File: rtl/alu_pipe_pkg.sv
// Shared types and default configuration for the ALU pipeline and its
// future mul/div siblings.
package alu_pipe_pkg;

   // Default configuration (ooo_config).
   localparam int unsigned DEF_XLEN        = 32;
   localparam int unsigned DEF_ROB_BITS    = 5;
   localparam int unsigned DEF_PREG_BITS   = 6;
   localparam int unsigned DEF_RREG_BITS   = 5;
   localparam int unsigned DEF_NUM_BR      = 4;
   localparam int unsigned DEF_BR_IDX_BITS = (DEF_NUM_BR > 1) ? $clog2(DEF_NUM_BR) : 1;

   // ALU op encoding (rv32i_types), extended with passb/min/max.
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SLL   = 4'd1,
      ALU_SRA   = 4'd2,
      ALU_SUB   = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SRL   = 4'd5,
      ALU_OR    = 4'd6,
      ALU_AND   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10,
      ALU_MIN   = 4'd11,
      ALU_MAX   = 4'd12
   } alu_ops_t;

   // Pipeline entry at the default configuration.
   typedef struct packed {
      logic                     valid;
      logic [DEF_XLEN-1:0]      data;
      logic [DEF_ROB_BITS-1:0]  rob;
      logic [DEF_RREG_BITS-1:0] rd;
      logic [DEF_PREG_BITS-1:0] pd;
      logic [DEF_NUM_BR-1:0]    mask;
   } alu_pipe_entry_t;

endpackage

// File: rtl/alu_pipe_datapath.sv
// Combinational integer op evaluator; undefined op codes yield X.
module alu_datapath
   import alu_pipe_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] f
);

   localparam int unsigned SH_BITS = $clog2(XLEN);

   logic [SH_BITS-1:0] shamt;
   logic               lt_s;
   logic               lt_u;

   // Evaluate the selected op on the two operands
   always_comb begin
      shamt = b[SH_BITS-1:0];
      lt_s  = $signed(a) < $signed(b);
      lt_u  = a < b;
      f     = 'x;
      case (op)
         ALU_ADD:   f = a + b;
         ALU_SUB:   f = a - b;
         ALU_SLL:   f = a << shamt;
         ALU_SRL:   f = a >> shamt;
         ALU_SRA:   f = $signed(a) >>> shamt;
         ALU_XOR:   f = a ^ b;
         ALU_OR:    f = a | b;
         ALU_AND:   f = a & b;
         ALU_SLT:   f = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU:  f = {{(XLEN-1){1'b0}}, lt_u};
         ALU_PASSB: f = b;
         ALU_MIN:   f = lt_s ? a : b;
         ALU_MAX:   f = lt_s ? b : a;
         default:   f = 'x;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Stallable ALU pipeline with branch-mask tracking and CDB backpressure.
// Stage 0 holds the raw operands; the result is formed from stage 0 and
// carried unchanged through the remaining stages.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter  int unsigned XLEN      = DEF_XLEN,
   parameter  int unsigned STAGES    = 2,
   parameter  int unsigned ROB_BITS  = DEF_ROB_BITS,
   parameter  int unsigned PREG_BITS = DEF_PREG_BITS,
   parameter  int unsigned RREG_BITS = DEF_RREG_BITS,
   parameter  int unsigned NUM_BR    = DEF_NUM_BR,
   localparam int unsigned BR_W      = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [XLEN-1:0]      in_a,
   input  logic [XLEN-1:0]      in_b,
   input  logic [ROB_BITS-1:0]  in_rob,
   input  logic [RREG_BITS-1:0] in_rd,
   input  logic [PREG_BITS-1:0] in_pd,
   input  logic [NUM_BR-1:0]    in_mask,
   input  logic                 br_valid,
   input  logic                 br_mispred,
   input  logic [BR_W-1:0]      br_idx,
   input  logic                 flush_all,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_data,
   output logic [ROB_BITS-1:0]  out_rob,
   output logic [RREG_BITS-1:0] out_rd,
   output logic [PREG_BITS-1:0] out_pd,
   output logic [NUM_BR-1:0]    out_mask
);

   typedef struct packed {
      logic [ROB_BITS-1:0]  rob;
      logic [RREG_BITS-1:0] rd;
      logic [PREG_BITS-1:0] pd;
   } tag_t;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] kill;
   logic [STAGES-1:0] ev;
   logic [STAGES-1:0] load;
   tag_t              tag_q  [STAGES];
   logic [NUM_BR-1:0] mask_q [STAGES];

   logic [3:0]        op0_q;
   logic [XLEN-1:0]   a0_q;
   logic [XLEN-1:0]   b0_q;
   logic [XLEN-1:0]   res;

   logic              mispred;
   logic              in_kill;
   logic [NUM_BR-1:0] clr;
   logic [NUM_BR-1:0] in_mask_upd;

   alu_datapath #(.XLEN(XLEN)) u_datapath (
      .op (op0_q),
      .a  (a0_q),
      .b  (b0_q),
      .f  (res)
   );

   // Kill/resolve decode and stage-advance control. A stage may load when it
   // or any stage downstream of it is empty (after kills), or the output is
   // accepted; this is the closed form of the per-stage "empty or moving" chain.
   always_comb begin
      logic acc;
      mispred     = br_valid & br_mispred;
      clr         = (br_valid & ~br_mispred) ? (NUM_BR'(1) << br_idx) : '0;
      in_mask_upd = in_mask & ~clr;
      in_kill     = flush_all | (mispred & in_mask[br_idx]);
      for (int unsigned i = 0; i < STAGES; i++) begin
         kill[i] = flush_all | (mispred & mask_q[i][br_idx]);
         ev[i]   = vld_q[i] & ~kill[i];
      end
      for (int unsigned i = 0; i < STAGES; i++) begin
         acc = out_ready;
         for (int unsigned j = i; j < STAGES; j++) acc = acc | ~ev[j];
         load[i] = acc;
      end
   end

   assign in_ready  = load[0];
   assign out_valid = ev[STAGES-1];
   assign out_rob   = tag_q[STAGES-1].rob;
   assign out_rd    = tag_q[STAGES-1].rd;
   assign out_pd    = tag_q[STAGES-1].pd;
   assign out_mask  = mask_q[STAGES-1] & ~clr;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         // Stage 0 valid: take the issued op (unless killed) or keep the surviving entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)         vld_q[0] <= 1'b0;
            else if (load[0]) vld_q[0] <= in_valid & ~in_kill;
            else              vld_q[0] <= ev[0];
         end

         // Stage 0 payload: capture operands and tags, keep resolving mask bits while held
         always_ff @(posedge clk) begin
            if (load[0]) begin
               op0_q     <= in_op;
               a0_q      <= in_a;
               b0_q      <= in_b;
               tag_q[0]  <= '{rob: in_rob, rd: in_rd, pd: in_pd};
               mask_q[0] <= in_mask_upd;
            end else begin
               mask_q[0] <= mask_q[0] & ~clr;
            end
         end
      end else begin : g_body
         // Stage i valid: advance from stage i-1 or keep the surviving entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)         vld_q[i] <= 1'b0;
            else if (load[i]) vld_q[i] <= ev[i-1];
            else              vld_q[i] <= ev[i];
         end

         // Stage i tags/mask: advance or hold, clearing resolved branch bits
         always_ff @(posedge clk) begin
            if (load[i]) begin
               tag_q[i]  <= tag_q[i-1];
               mask_q[i] <= mask_q[i-1] & ~clr;
            end else begin
               mask_q[i] <= mask_q[i] & ~clr;
            end
         end
      end
   end

   if (STAGES == 1) begin : g_data_single
      assign out_data = res;
   end else begin : g_data_multi
      logic [XLEN-1:0] data_q [1:STAGES-1];

      // Result register chain: stage 1 latches the ALU result, later stages copy it
      always_ff @(posedge clk) begin
         if (load[1]) data_q[1] <= res;
         for (int unsigned i = 2; i < STAGES; i++) begin
            if (load[i]) data_q[i] <= data_q[i-1];
         end
      end

      assign out_data = data_q[STAGES-1];
   end

endmodule
